// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl: fixed-priority external interrupt controller with claim/complete.
// Ports: clk, rst_n, irq_src_i, req_i/we_i/addr_i/wdata_i -> rdata_o/ack_o, intr_o.
// Build option: URISCV_IRQ_SYNC_EN adds a 2-flop synchronizer on every source.
module uriscv_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               intr_o
);

  localparam int PAD = 32 - NUM_SRC;

  localparam logic [2:0] R_PEND  = 3'd0;
  localparam logic [2:0] R_EN    = 3'd1;
  localparam logic [2:0] R_EDGE  = 3'd2;
  localparam logic [2:0] R_CLAIM = 3'd3;
  localparam logic [2:0] R_ACT   = 3'd4;

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] en_q;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] act_q;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] cpl_oh;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] act_nxt;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [4:0]         win_id;
  logic [2:0]         sel;
  logic               rd_en;
  logic               claim;
  logic               cpl;
  logic [31:0]        rd_mux;
  logic               unused_ok;

`ifdef URISCV_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src_i;
`endif

  assign unused_ok = ^{addr_i[1:0], wdata_i};

  assign sel   = addr_i[4:2];
  assign rd_en = req_i & ~we_i;
  assign claim = rd_en & (sel == R_CLAIM);
  assign cpl   = req_i & we_i & (sel == R_CLAIM);

  assign elig = pend_q & en_q & ~act_q;
  assign rise = src_s & ~src_d;

  // lowest index wins: scan downwards so the last hit is the lowest
  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = 5'(i + 1);
      end
    end
  end

  // out-of-range or zero IDs match no bit and fall out naturally
  always_comb begin
    cpl_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cpl_oh[i] = cpl & (wdata_i[4:0] == 5'(i + 1));
    end
  end

  assign claim_clr = claim ? (win_oh & edge_q) : '0;
  assign act_nxt   = (act_q | (claim ? win_oh : '0)) & ~cpl_oh;

  // edge: sticky until claimed, a new edge beats the claim clear
  // level: follows the source, masked by in-service
  assign pend_nxt = (edge_q & ((pend_q & ~claim_clr) | rise))
                  | (~edge_q & src_s & ~act_nxt);

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      R_PEND:  rd_mux = {{PAD{1'b0}}, pend_q};
      R_EN:    rd_mux = {{PAD{1'b0}}, en_q};
      R_EDGE:  rd_mux = {{PAD{1'b0}}, edge_q};
      R_CLAIM: rd_mux = {27'd0, win_id};
      R_ACT:   rd_mux = {{PAD{1'b0}}, act_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      act_q   <= '0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
      intr_o  <= 1'b0;
    end else begin
      src_d   <= src_s;
      pend_q  <= pend_nxt;
      act_q   <= act_nxt;
      ack_o   <= req_i;
      rdata_o <= rd_en ? rd_mux : '0;
      intr_o  <= |elig;
      if (req_i && we_i && sel == R_EN) begin
        en_q <= wdata_i[NUM_SRC-1:0];
      end
      if (req_i && we_i && sel == R_EDGE) begin
        edge_q <= wdata_i[NUM_SRC-1:0];
      end
    end
  end

endmodule

// File: tb/tb_uriscv_irq_ctrl.sv
// tb_uriscv_irq_ctrl: directed and random stimulus for uriscv_irq_ctrl.
// Checks ack/rdata/intr every cycle against a rule-level reference model.
module tb_uriscv_irq_ctrl;

  localparam int N = 8;
`ifdef URISCV_IRQ_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] src = '0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        intr_o;

  int total = 0;
  int bad = 0;

  logic [N-1:0] m_pend, m_en, m_edge, m_act, m_prev;
  logic [N-1:0] m_hist [0:2];
  logic         m_ack, m_intr;
  logic [31:0]  m_rdata;

  uriscv_irq_ctrl #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src_i (src),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata_o),
    .ack_o     (ack_o),
    .intr_o    (intr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_edge = '0; m_act = '0; m_prev = '0;
    m_ack = 1'b0; m_intr = 1'b0; m_rdata = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
  endtask

  // one clock edge of the controller, from the register-map rules
  task automatic model_step();
    logic [N-1:0] eff, rise, elig, nact, npend, clr;
    logic [31:0]  rd;
    int win, id;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = src;
    eff  = m_hist[DLY];
    rise = eff & ~m_prev;
    elig = m_pend & m_en & ~m_act;
    win = 0;
    for (int i = 0; i < N; i++)
      if (elig[i] && win == 0) win = i + 1;
    rd = '0; clr = '0; nact = m_act;
    if (req && !we) begin
      case (addr[4:2])
        3'd0: rd = 32'(m_pend);
        3'd1: rd = 32'(m_en);
        3'd2: rd = 32'(m_edge);
        3'd3: begin
          rd = 32'(win);
          if (win != 0) begin
            nact[win-1] = 1'b1;
            clr[win-1]  = m_edge[win-1];
          end
        end
        3'd4: rd = 32'(m_act);
        default: rd = '0;
      endcase
    end else if (req && we && addr[4:2] == 3'd3) begin
      id = int'(wdata[4:0]);
      if (id >= 1 && id <= N) nact[id-1] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) npend[i] = (m_pend[i] & ~clr[i]) | rise[i];
      else           npend[i] = eff[i] & ~nact[i];
    end
    m_intr  = |elig;
    m_ack   = req;
    m_rdata = rd;
    if (req && we && addr[4:2] == 3'd1) m_en = wdata[N-1:0];
    if (req && we && addr[4:2] == 3'd2) m_edge = wdata[N-1:0];
    m_pend = npend;
    m_act  = nact;
    m_prev = eff;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ack", 32'(ack_o), 32'(m_ack));
    chk("intr", 32'(intr_o), 32'(m_intr));
    if (m_ack) chk("rdata", rdata_o, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic access(input logic w, input logic [4:0] a,
                        input logic [31:0] d, output logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    r = rdata_o;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    access(1'b0, a, '0, r);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r;
    access(1'b1, a, d, r);
  endtask

  initial begin
    logic [31:0] r;
    int sel;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_intr", 32'(intr_o), 0);

    // 1: reset values
    rd("t1_pend", 5'h00, 0);
    rd("t1_en", 5'h04, 0);
    rd("t1_edge", 5'h08, 0);
    rd("t1_claim", 5'h0C, 0);
    rd("t1_act", 5'h10, 0);
    chk("t1_intr", 32'(intr_o), 0);

    // 2: level source, claim and complete while still asserted
    wr(5'h04, 32'h05);
    src = 8'h04;
    idle(6);
    chk("t2_intr_on", 32'(intr_o), 1);
    rd("t2_claim", 5'h0C, 3);
    idle(2);
    chk("t2_intr_off", 32'(intr_o), 0);
    rd("t2_act", 5'h10, 32'h04);
    wr(5'h0C, 3);
    idle(3);
    chk("t2_intr_again", 32'(intr_o), 1);
    src = '0;
    idle(6);
    chk("t2_intr_idle", 32'(intr_o), 0);

    // 3: edge pulse
    wr(5'h08, 32'h01);
    wr(5'h04, 32'h01);
    src = 8'h01;
    tick();
    src = '0;
    idle(6);
    rd("t3_pend", 5'h00, 32'h01);
    chk("t3_intr", 32'(intr_o), 1);
    rd("t3_claim", 5'h0C, 1);
    rd("t3_pend_clr", 5'h00, 0);
    rd("t3_claim2", 5'h0C, 0);
    wr(5'h0C, 1);
    wr(5'h08, 32'h00);

    // 4: priority between two level sources
    wr(5'h04, 32'hFF);
    src = 8'h22;
    idle(6);
    rd("t4_claim_a", 5'h0C, 2);
    rd("t4_claim_b", 5'h0C, 6);
    src = '0;
    wr(5'h0C, 6);
    wr(5'h0C, 2);
    rd("t4_act", 5'h10, 0);
    idle(4);

    // 5: disabled edge stays pending, fires once enabled
    wr(5'h04, 32'h00);
    wr(5'h08, 32'h08);
    src = 8'h08;
    tick();
    src = '0;
    idle(6);
    rd("t5_pend", 5'h00, 32'h08);
    chk("t5_intr_masked", 32'(intr_o), 0);
    wr(5'h04, 32'h08);
    chk("t5_intr_lat", 32'(intr_o), 0);
    tick();
    chk("t5_intr_on", 32'(intr_o), 1);
    rd("t5_claim", 5'h0C, 4);
    wr(5'h0C, 4);

    // 6: edge during claim, bad completes, reset mid-access
    wr(5'h08, 32'h01);
    wr(5'h04, 32'h01);
    src = 8'h01;
    tick();
    src = '0;
    idle(6);
    src = 8'h01;
    idle(DLY);
    rd("t6_claim", 5'h0C, 1);
    rd("t6_pend_kept", 5'h00, 32'h01);
    src = '0;
    wr(5'h0C, 0);
    rd("t6_act_id0", 5'h10, 32'h01);
    wr(5'h0C, 9);
    rd("t6_act_id9", 5'h10, 32'h01);
    wr(5'h0C, 1);
    rd("t6_act_clr", 5'h10, 0);
    idle(3);

    // random phase
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) src = N'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 3) begin
        req = 1'b1; we = 1'b0;
        addr = 5'(12 | $urandom_range(0, 3));
      end else if (sel < 5) begin
        req = 1'b1; we = 1'b1; addr = 5'h0C;
        wdata = 32'($urandom_range(0, 10));
      end else if (sel < 7) begin
        req = 1'b1; we = 1'($urandom_range(0, 1));
        addr = 5'($urandom_range(0, 31));
        wdata = $urandom;
      end else begin
        req = 1'b0;
      end
      tick();
      req = 1'b0; we = 1'b0;
    end

    // reset asserted while a write is in flight
    src = '0;
    req = 1'b1; we = 1'b1; addr = 5'h04; wdata = 32'hFF;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ack", 32'(ack_o), 0);
    chk("mid_rst_intr", 32'(intr_o), 0);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd("mid_rst_en", 5'h04, 0);
    rd("mid_rst_pend", 5'h00, 0);
    rd("mid_rst_act", 5'h10, 0);
    rd("mid_rst_edge", 5'h08, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
